// File: rtl/edge_window_pkg.sv
// Shared types and default constants for the edge window counter.
// Imported by sig_conditioner and edge_window_counter.
package edge_window_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILTER_LEN_DEF  = 4;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    COUNT   = 2'd1,
    PUBLISH = 2'd2
  } ew_state_e;

endpackage

// File: rtl/sig_conditioner.sv
// Synchronizer, optional glitch filter and rising-edge detector.
// Define GLITCH_FILTER_EN to insert the FILTER_LEN stable-sample filter.
module sig_conditioner
  import edge_window_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   lvl;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d = lvl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] fcnt_q;
  logic [FCW-1:0] fcnt_d;
  logic           filt_q;
  logic           filt_d;

  // Flip only on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  assign rise_o = lvl & ~prev_q;

endmodule

// File: rtl/edge_window_counter.sv
// Counts rising edges of sig_in per controller-defined window.
// Optional GLITCH_FILTER_EN enables the input glitch filter.
module edge_window_counter
  import edge_window_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             is_collecting,
  input  logic             is_latching,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             protocol_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rise;

  sig_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_cond (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise_o (rise)
  );

  ew_state_e        state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_ovf_q, win_ovf_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             counting;
  logic             publish;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    win_ovf_d = win_ovf_q;
    cnt_out_d = cnt_out_q;
    ovf_d     = ovf_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    counting  = 1'b0;
    publish   = 1'b0;

    unique case (state_q)
      ARMED: begin
        if (is_latching) begin
          err_d = 1'b1;
        end else if (is_collecting) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        counting = 1'b1;
        publish  = is_latching;
      end
      PUBLISH: begin
        counting = is_collecting;
        publish  = is_latching;
        if (!is_latching) begin
          state_d = is_collecting ? COUNT : ARMED;
        end
      end
      default: state_d = ARMED;
    endcase

    // An edge in the strobe cycle opens the next window.
    if (publish) begin
      state_d   = PUBLISH;
      err_d     = err_q | is_collecting;
      cnt_out_d = win_cnt_q;
      ovf_d     = win_ovf_q;
      vld_d     = 1'b1;
      win_cnt_d = CNT_W'(rise);
      win_ovf_d = 1'b0;
    end else if (counting && rise) begin
      if (win_cnt_q == CNT_MAX) begin
        win_ovf_d = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARMED;
      win_cnt_q <= '0;
      win_ovf_q <= 1'b0;
      cnt_out_q <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_ovf_q <= win_ovf_d;
      cnt_out_q <= cnt_out_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign count_out    = cnt_out_q;
  assign count_valid  = vld_q;
  assign overflow     = ovf_q;
  assign protocol_err = err_q;

endmodule

// File: doc/edge_window_counter.md
EDGE_WINDOW_COUNTER -- requirements
Module: edge_window_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the edge count.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, setting the depth of the input synchronizer (minimum 2).
REQ-003 The block SHALL have parameter FILTER_LEN, default 4, setting the stable-sample count used by the glitch filter.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock (48 MHz).
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port sig_in, input, 1 bit: asynchronous measured signal.
REQ-007 The block SHALL have port is_collecting, input, 1 bit: window-open level from the window controller.
REQ-008 The block SHALL have port is_latching, input, 1 bit: one-cycle window-close strobe from the window controller.
REQ-009 The block SHALL have port count_out, output, CNT_W bits: rising-edge count of the last completed window.
REQ-010 The block SHALL have port count_valid, output, 1 bit: one-cycle pulse when count_out updates.
REQ-011 The block SHALL have port overflow, output, 1 bit: the published window saturated.
REQ-012 The block SHALL have port protocol_err, output, 1 bit: sticky flag for controller misbehaviour.

Function
REQ-013 sig_in SHALL pass through a SYNC_STAGES flip-flop synchronizer; a rising edge SHALL be detected as a 0-to-1 transition of the synchronized (or filtered) level.
REQ-014 The FSM SHALL have three states: ARMED, COUNT and PUBLISH.
REQ-015 The FSM SHALL transition ARMED->COUNT when is_collecting=1, COUNT->PUBLISH when is_latching=1, and PUBLISH->COUNT if is_collecting=1, otherwise PUBLISH->ARMED.
REQ-016 In COUNT, each detected edge SHALL increment the window counter by 1, saturating at 2^CNT_W-1; an increment attempted at saturation SHALL set the window overflow bit.
REQ-017 In ARMED, detected edges SHALL be ignored.
REQ-018 In the cycle after the is_latching strobe, count_out and overflow SHALL load the window counter and overflow bit, and count_valid SHALL be 1 for exactly one cycle.
REQ-019 At that same point, the window counter and window overflow bit SHALL clear.
REQ-020 An edge detected in the is_latching cycle SHALL be counted into the next window (counter loads 1, not 0), so no edge is lost or double-counted.
REQ-021 count_out and overflow SHALL hold their value between publishes.
REQ-022 If is_collecting=1 and is_latching=1 in the same cycle, latching SHALL take priority and protocol_err SHALL set.
REQ-023 If is_latching=1 while in ARMED, nothing SHALL publish and protocol_err SHALL set.
REQ-024 protocol_err SHALL clear only on reset.
REQ-025 Latency from a sig_in rise to the counter increment SHALL be SYNC_STAGES+1 cycles, plus FILTER_LEN cycles when the glitch filter is enabled.

Reset
REQ-026 While reset=1 at a clk edge: state SHALL be ARMED; counter, count_out, count_valid, overflow and protocol_err SHALL be 0; the synchronizer and filter SHALL be 0.
REQ-027 A reset mid-window SHALL discard the partial count with no count_valid pulse.

Configuration
REQ-028 With GLITCH_FILTER_EN defined, the filtered level SHALL change only after the synchronized level differs from it for FILTER_LEN consecutive cycles; shorter pulses SHALL be ignored.
REQ-029 Without GLITCH_FILTER_EN, the edge detector SHALL use the synchronized level directly, and FILTER_LEN SHALL be unused.

Structure
REQ-030 Package edge_window_pkg SHALL hold the state typedef (ARMED, COUNT, PUBLISH) and the default constants CNT_W_DEF=16, SYNC_STAGES_DEF=2 and FILTER_LEN_DEF=4.
REQ-031 Sub-module sig_conditioner SHALL contain the synchronizer, the optional glitch filter and the rising-edge detector, and SHALL output a one-cycle rise pulse.

Verification
REQ-032 The bench SHALL cover: a 200-cycle window with 10 clean pulses (period 20) -> count_out=10, count_valid high 1 cycle, overflow=0.
REQ-033 The bench SHALL cover: CNT_W=4 with 20 pulses in a window -> count_out=15, overflow=1; the next window with 3 pulses -> count_out=3, overflow=0.
REQ-034 The bench SHALL cover: an edge timed to reach detection in the is_latching cycle -> excluded from the current publish, included in the next (next count = pulses+1).
REQ-035 The bench SHALL cover, with GLITCH_FILTER_EN: 2-cycle pulses -> count 0; 8-cycle pulses ×5 -> count 5; without the macro, 2-cycle pulses ×5 -> count 5.
REQ-036 The bench SHALL cover: is_collecting and is_latching both high for 1 cycle -> publish occurs and protocol_err=1 until reset.
REQ-037 The bench SHALL cover: reset asserted mid-window after 7 edges -> no count_valid, count_out=0; the next full window with 4 edges -> count_out=4.
